// File: rtl/frame_buffer_reader.sv
// frame_buffer_reader: scans a captured frame out of BRAM in raster order,
// one pixel per cycle, and tags each returning pixel with its address,
// column, row and first/last markers.
// Optional feature macro: FRAME_BUFFER_READER_CONTINUOUS_EN (free-running rescan).
module frame_buffer_reader #(
    parameter int IMAGE_WIDTH  = 320,
    parameter int IMAGE_HEIGHT = 240,
    parameter int ADDR_BITS    = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT),
    parameter int RD_LATENCY   = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            frame_ready,
    input  logic [11:0]                     rddata,
    output logic [ADDR_BITS-1:0]            rdaddress,
    output logic                            pix_valid,
    output logic [11:0]                     pix_data,
    output logic [ADDR_BITS-1:0]            pix_addr,
    output logic [$clog2(IMAGE_WIDTH)-1:0]  pix_col,
    output logic [$clog2(IMAGE_HEIGHT)-1:0] pix_row,
    output logic                            pix_first,
    output logic                            pix_last,
    output logic                            frame_done,
    output logic                            busy,
    output logic [7:0]                      overrun_count
);

    localparam int COL_W = $clog2(IMAGE_WIDTH);
    localparam int ROW_W = $clog2(IMAGE_HEIGHT);
    localparam int NPIX  = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NPIX - 1);
    localparam logic [COL_W-1:0]     LAST_COL  = COL_W'(IMAGE_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    // Coordinates of the read being issued this cycle; they ride the pipe
    // with the address so the output side never needs a divide/modulo.
    logic [COL_W-1:0]       col_q, col_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic                   pend_q, pend_d;
    logic [7:0]             ovr_q, ovr_d;
    logic                   done_q;
    logic                   issue;
    logic                   last_out;

    logic [RD_LATENCY-1:0]                vld_pipe;
    logic [RD_LATENCY-1:0][ADDR_BITS-1:0] addr_pipe;
    logic [RD_LATENCY-1:0][COL_W-1:0]     col_pipe;
    logic [RD_LATENCY-1:0][ROW_W-1:0]     row_pipe;

    // start_req launches a scan from IDLE or at the end of DRAIN;
    // queue_req feeds the pending flag / overrun counter while busy.
    logic start_req, queue_req;
`ifdef FRAME_BUFFER_READER_CONTINUOUS_EN
    logic unused_frame_ready;
    assign unused_frame_ready = frame_ready;
    assign start_req = 1'b1;
    assign queue_req = 1'b0;
`else
    assign start_req = frame_ready;
    assign queue_req = frame_ready;
`endif

    assign last_out = vld_pipe[RD_LATENCY-1] && (addr_pipe[RD_LATENCY-1] == LAST_ADDR);

    // Next-state, read-address sequencing and pending/overrun bookkeeping.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        col_d   = col_q;
        row_d   = row_q;
        pend_d  = pend_q;
        ovr_d   = ovr_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_req || pend_q) begin
                    state_d = SCAN;
                    addr_d  = '0;
                    col_d   = '0;
                    row_d   = '0;
                    pend_d  = 1'b0;
                end
            end
            SCAN: begin
                issue = 1'b1;
                if (addr_q == LAST_ADDR) begin
                    state_d = DRAIN;
                end else begin
                    addr_d = addr_q + ADDR_BITS'(1);
                    if (col_q == LAST_COL) begin
                        col_d = '0;
                        row_d = row_q + ROW_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
                if (queue_req) begin
                    if (pend_q) begin
                        if (ovr_q != 8'hFF) ovr_d = ovr_q + 8'd1;
                    end else begin
                        pend_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (last_out) begin
                    // A request landing on the final drain cycle restarts
                    // immediately; if one was already pending it stays queued.
                    if (pend_q || start_req) begin
                        state_d = SCAN;
                        addr_d  = '0;
                        col_d   = '0;
                        row_d   = '0;
                        pend_d  = pend_q && queue_req;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (queue_req) begin
                    if (pend_q) begin
                        if (ovr_q != 8'hFF) ovr_d = ovr_q + 8'd1;
                    end else begin
                        pend_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            pend_q  <= 1'b0;
            ovr_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            col_q   <= col_d;
            row_q   <= row_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            done_q  <= last_out;
        end
    end

    // Tag pipeline matching the BRAM read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            addr_pipe <= '0;
            col_pipe  <= '0;
            row_pipe  <= '0;
        end else begin
            vld_pipe[0]  <= issue;
            addr_pipe[0] <= addr_q;
            col_pipe[0]  <= col_q;
            row_pipe[0]  <= row_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
                col_pipe[i]  <= col_pipe[i-1];
                row_pipe[i]  <= row_pipe[i-1];
            end
        end
    end

    // Pixel outputs are zeroed whenever no read is returning.
    assign rdaddress     = addr_q;
    assign pix_valid     = vld_pipe[RD_LATENCY-1];
    assign pix_data      = pix_valid ? rddata : '0;
    assign pix_addr      = pix_valid ? addr_pipe[RD_LATENCY-1] : '0;
    assign pix_col       = pix_valid ? col_pipe[RD_LATENCY-1] : '0;
    assign pix_row       = pix_valid ? row_pipe[RD_LATENCY-1] : '0;
    assign pix_first     = pix_valid && (addr_pipe[RD_LATENCY-1] == '0);
    assign pix_last      = last_out;
    assign frame_done    = done_q;
    assign busy          = (state_q != IDLE);
    assign overrun_count = ovr_q;

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Directed bench for frame_buffer_reader on a 4x2 image, RD_LATENCY=2,
// with a BRAM model whose data equals its address.
module tb_frame_buffer_reader;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int L  = 2;
    localparam int AB = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          frame_ready;
    logic [11:0]   rddata;
    logic [AB-1:0] rdaddress;
    logic          pix_valid;
    logic [11:0]   pix_data;
    logic [AB-1:0] pix_addr;
    logic [1:0]    pix_col;
    logic [0:0]    pix_row;
    logic          pix_first, pix_last, frame_done, busy;
    logic [7:0]    overrun_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    frame_buffer_reader #(
        .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .ADDR_BITS(AB), .RD_LATENCY(L)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_ready(frame_ready), .rddata(rddata),
        .rdaddress(rdaddress), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_addr(pix_addr), .pix_col(pix_col), .pix_row(pix_row),
        .pix_first(pix_first), .pix_last(pix_last), .frame_done(frame_done),
        .busy(busy), .overrun_count(overrun_count)
    );

    always #10 clk = ~clk;

    // BRAM model: two-cycle registered read, data = address.
    logic [AB-1:0] m1, m2;
    always @(posedge clk) begin
        m1 <= rdaddress;
        m2 <= m1;
    end
    assign rddata = {{(12-AB){1'b0}}, m2};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        frame_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic pulse_at(input int c);
        run_to(c);
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".rdaddress"}, 32'(rdaddress), 0);
        check({tag, ".pix_valid"}, 32'(pix_valid), 0);
        check({tag, ".pix_data"},  32'(pix_data), 0);
        check({tag, ".pix_addr"},  32'(pix_addr), 0);
        check({tag, ".pix_last"},  32'(pix_last), 0);
        check({tag, ".frame_done"},32'(frame_done), 0);
        check({tag, ".busy"},      32'(busy), 0);
        check({tag, ".overrun"},   32'(overrun_count), 0);
    endtask

    initial begin
        int p;
        logic ev;
        int seen_done;

        // Reset state
        rst_n = 1'b0;
        frame_ready = 1'b0;
        #5;
        check_all_zero("reset");

        // Single frame: request in cycle 10
        reset_dut();
        pulse_at(10);
        while (cyc <= 22) begin
            ev = (cyc >= 13) && (cyc <= 20);
            p  = cyc - 13;
            check("s1.rdaddress", 32'(rdaddress), (cyc <= 18) ? 32'(cyc - 11) : 32'd7);
            check("s1.pix_valid", 32'(pix_valid), 32'(ev));
            if (ev) begin
                check("s1.pix_data",  32'(pix_data), 32'(p));
                check("s1.pix_addr",  32'(pix_addr), 32'(p));
                check("s1.pix_col",   32'(pix_col),  32'(p % W));
                check("s1.pix_row",   32'(pix_row),  32'(p / W));
                check("s1.pix_first", 32'(pix_first), 32'(p == 0));
                check("s1.pix_last",  32'(pix_last),  32'(p == 7));
            end
            check("s1.frame_done", 32'(frame_done), 32'(cyc == 21));
            check("s1.busy",       32'(busy),       32'(cyc <= 20));
            step();
        end
        check("s1.overrun", 32'(overrun_count), 0);

        // Second request during scan: restart right after drain
        reset_dut();
        pulse_at(10);
        pulse_at(14);
        run_to(21);
        check("s2.busy@21", 32'(busy), 1);
        check("s2.rdaddress@21", 32'(rdaddress), 0);
        check("s2.pix_valid@21", 32'(pix_valid), 0);
        run_to(23);
        check("s2.pix_first@23", 32'(pix_first), 1);
        check("s2.pix_addr@23", 32'(pix_addr), 0);
        check("s2.overrun", 32'(overrun_count), 0);
        run_to(30);
        check("s2.pix_last@30", 32'(pix_last), 1);
        run_to(31);
        check("s2.frame_done@31", 32'(frame_done), 1);
        check("s2.busy@31", 32'(busy), 0);

        // Three requests while busy: one restart, two overruns
        reset_dut();
        pulse_at(10);
        pulse_at(12);
        pulse_at(14);
        pulse_at(16);
        run_to(21);
        check("s3.rdaddress@21", 32'(rdaddress), 0);
        check("s3.busy@21", 32'(busy), 1);
        check("s3.overrun", 32'(overrun_count), 2);
        run_to(31);
        check("s3.frame_done@31", 32'(frame_done), 1);
        check("s3.busy@31", 32'(busy), 0);
        run_to(36);
        check("s3.busy@36", 32'(busy), 0);
        check("s3.pix_valid@36", 32'(pix_valid), 0);

        // Reset mid-scan: immediate zeroing, no frame_done, stays idle
        reset_dut();
        pulse_at(10);
        run_to(15);
        check("s4.busy@15", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("s4.async");
        step();
        step();
        rst_n = 1'b1;
        seen_done = 0;
        repeat (15) begin
            step();
            if (frame_done || busy || pix_valid) seen_done++;
        end
        check("s4.quiet_after_reset", 32'(seen_done), 0);
        pulse_at(cyc);
        check("s4.restart.busy", 32'(busy), 1);
        check("s4.restart.rdaddress", 32'(rdaddress), 0);
        step();
        step();
        check("s4.restart.pix_first", 32'(pix_first), 1);

        // Held request: overrun counter saturates at 255
        reset_dut();
        frame_ready = 1'b1;
        repeat (400) step();
        frame_ready = 1'b0;
        check("s5.overrun_sat", 32'(overrun_count), 255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
